// File: rtl/stream_pkg.sv
// stream_pkg
// Shared helpers for the byte-stream blocks (stream_normalizer, stream_repacker).
//   popcount    : number of set bits in a keep mask (masks up to KEEP_MAX bits,
//                 callers zero-extend narrower masks).
//   cnt_encode  : byte count 1..out_bytes -> out_cnt field (out_bytes maps to 0).
//   cnt_decode  : out_cnt field -> byte count (0 maps back to out_bytes).
package stream_pkg;

    localparam int unsigned KEEP_MAX = 64;

    function automatic int unsigned popcount(input logic [KEEP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic int unsigned cnt_encode(input int unsigned n, input int unsigned out_bytes);
        return (n == out_bytes) ? 32'd0 : n;
    endfunction

    function automatic int unsigned cnt_decode(input int unsigned c, input int unsigned out_bytes);
        return (c == 32'd0) ? out_bytes : c;
    endfunction

endpackage

// File: rtl/stream_keep_compactor.sv
// stream_keep_compactor
// Combinational compaction of a sparse input beat: the kept bytes are packed to
// the low end of comp_data in ascending index order; the upper bytes are zero.
// Ports:
//   in_data   [IN_BYTES*8]          input bytes, byte i = in_data[i*8+:8]
//   in_keep   [IN_BYTES]            per-byte keep mask (any pattern)
//   comp_data [IN_BYTES*8]          packed kept bytes, lowest byte first
//   comp_cnt  [$clog2(IN_BYTES+1)]  number of kept bytes
module stream_keep_compactor
    import stream_pkg::*;
#(
    parameter int unsigned IN_BYTES = 8
) (
    input  logic [IN_BYTES*8-1:0]          in_data,
    input  logic [IN_BYTES-1:0]            in_keep,
    output logic [IN_BYTES*8-1:0]          comp_data,
    output logic [$clog2(IN_BYTES+1)-1:0]  comp_cnt
);

    localparam int unsigned CW = $clog2(IN_BYTES + 1);

    logic [CW-1:0]       w_pre  [IN_BYTES];   // kept bytes below index i
    logic [CW-1:0]       w_run;
    logic [7:0]          w_byte [IN_BYTES];
    logic [KEEP_MAX-1:0] w_keep_ext;

    // Each output slot j picks the kept input byte whose prefix count equals j.
    // Only one input byte can match, so OR-ing the candidates is a mux.
    always_comb begin
        w_run = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            w_pre[i] = w_run;
            if (in_keep[i]) w_run = w_run + CW'(1);
        end
        for (int j = 0; j < IN_BYTES; j++) begin
            w_byte[j] = 8'h00;
            for (int i = 0; i < IN_BYTES; i++) begin
                if (in_keep[i] && (w_pre[i] == CW'(j))) begin
                    w_byte[j] = w_byte[j] | in_data[i*8 +: 8];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < IN_BYTES; g++) begin : g_pack
            assign comp_data[g*8 +: 8] = w_byte[g];
        end
    endgenerate

    always_comb begin
        w_keep_ext = '0;
        w_keep_ext[IN_BYTES-1:0] = in_keep;
    end

    assign comp_cnt = CW'(popcount(w_keep_ext));

endmodule

// File: rtl/stream_repacker.sv
// stream_repacker
// Compacts sparse IN_BYTES-wide beats and repacks the kept bytes into full
// OUT_BYTES-wide words; only the last word of a packet may be partial. The
// output is driven from a register slot.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_data/in_keep/in_last    input beat, per-byte keep mask, end of packet
//   in_valid/in_ready          input handshake (in_ready independent of in_valid)
//   out_data                   packed output word, lowest byte first
//   out_cnt                    bytes in the last word (0 = OUT_BYTES), 0 otherwise
//   out_last                   final word of a packet
//   out_valid/out_ready        output handshake
module stream_repacker
    import stream_pkg::*;
#(
    parameter int unsigned IN_BYTES  = 8,
    parameter int unsigned OUT_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IN_BYTES*8-1:0]         in_data,
    input  logic [IN_BYTES-1:0]           in_keep,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_BYTES*8-1:0]        out_data,
    output logic [$clog2(OUT_BYTES)-1:0]  out_cnt,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned IN_BITS   = IN_BYTES * 8;
    localparam int unsigned OUT_BITS  = OUT_BYTES * 8;
    localparam int unsigned CNT_BITS  = $clog2(OUT_BYTES);
    localparam int unsigned BUF_BYTES = IN_BYTES + OUT_BYTES;
    localparam int unsigned LW        = $clog2(BUF_BYTES + 1);
    localparam int unsigned CW        = $clog2(IN_BYTES + 1);

    localparam logic [LW-1:0] L_OUT = LW'(OUT_BYTES);
    localparam logic [LW-1:0] L_MAX = LW'(OUT_BYTES - 1 + IN_BYTES);

    logic [7:0]          r_buf [BUF_BYTES];
    logic [LW-1:0]       r_lvl;
    logic                r_flush;
    logic [OUT_BITS-1:0] r_out_data;
    logic [CNT_BITS-1:0] r_out_cnt;
    logic                r_out_last;
    logic                r_out_valid;

    logic [IN_BITS-1:0]  w_comp_data;
    logic [CW-1:0]       w_comp_cnt;
    logic                w_slot_free;
    logic                w_pop_full;
    logic                w_pop_part;
    logic                w_pop;
    logic                w_pop_last;
    logic [LW-1:0]       w_take;
    logic [LW-1:0]       w_lvl_eff;
    logic [LW-1:0]       w_lvl_nxt;
    logic                w_ready;
    logic                w_acc;
    logic [7:0]          w_shift   [BUF_BYTES];
    logic [7:0]          w_buf_nxt [BUF_BYTES];
    logic [OUT_BITS-1:0] w_slot_data;

    stream_keep_compactor #(
        .IN_BYTES (IN_BYTES)
    ) u_compactor (
        .in_data   (in_data),
        .in_keep   (in_keep),
        .comp_data (w_comp_data),
        .comp_cnt  (w_comp_cnt)
    );

    // Pop decision and the level the input side sees after the pop.
    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_pop_full  = w_slot_free && (r_lvl >= L_OUT);
        w_pop_part  = w_slot_free && r_flush && (r_lvl != '0) && (r_lvl < L_OUT);
        w_pop       = w_pop_full || w_pop_part;
        w_pop_last  = w_pop_part || (w_pop_full && r_flush && (r_lvl == L_OUT));
        w_take      = w_pop_full ? L_OUT : r_lvl;
        w_lvl_eff   = w_pop ? (r_lvl - w_take) : r_lvl;
        // flush blocks the next packet until the current last word is in the slot,
        // so packets never share an output word.
        w_ready     = !r_flush && (w_lvl_eff < L_OUT);
        w_acc       = in_valid && w_ready;
        w_lvl_nxt   = w_lvl_eff + (w_acc ? LW'(w_comp_cnt) : '0);
    end

    assign in_ready = w_ready;

    // Shift out the popped word first, then append the compacted beat at lvl_eff.
    // A partial pop empties the buffer, so no shift is needed for it.
    always_comb begin
        for (int b = 0; b < BUF_BYTES; b++) begin
            if (w_pop_full) begin
                w_shift[b] = (b + OUT_BYTES < BUF_BYTES) ? r_buf[(b + OUT_BYTES) % BUF_BYTES] : 8'h00;
            end else begin
                w_shift[b] = r_buf[b];
            end
        end
        for (int b = 0; b < BUF_BYTES; b++) begin
            w_buf_nxt[b] = w_shift[b];
            if (w_acc) begin
                for (int i = 0; i < IN_BYTES; i++) begin
                    if ((LW'(i) < LW'(w_comp_cnt)) && ((w_lvl_eff + LW'(i)) == LW'(b))) begin
                        w_buf_nxt[b] = w_comp_data[i*8 +: 8];
                    end
                end
            end
        end
        w_slot_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (LW'(j) < w_take) w_slot_data[j*8 +: 8] = r_buf[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lvl       <= '0;
            r_flush     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_cnt   <= '0;
            r_out_data  <= '0;
        end else begin
            r_lvl <= w_lvl_nxt;
            // An empty flushed packet (lvl==0) has nothing to emit: just drop flush.
            if (w_acc && in_last) begin
                r_flush <= 1'b1;
            end else if (r_flush && (w_pop_last || (r_lvl == '0))) begin
                r_flush <= 1'b0;
            end
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_slot_data;
                r_out_last  <= w_pop_last;
                r_out_cnt   <= CNT_BITS'(cnt_encode(32'(w_take), OUT_BYTES));
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Buffer contents above lvl are don't-care, so the data array has no reset.
    always_ff @(posedge clk) begin
        r_buf <= w_buf_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_lvl <= L_MAX);
        end
    end

    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_repacker.sv
module tb_stream_repacker;
    import stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_cnt;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    stream_repacker #(
        .IN_BYTES  (8),
        .OUT_BYTES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // out_ready driver: 0 = hold low, 1 = hold high, 2 = toggle every cycle
    int rdy_mode = 1;
    int tog = 0;
    always begin
        @(posedge clk);
        #1;
        tog++;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = tog[0];
        endcase
    end

    // Output collector and stall-stability observer
    logic [34:0] rx_q[$];
    int          stab_chk  = 0;
    int          stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_word  = '0;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stab_chk++;
                if ({out_last, out_cnt, out_data} !== prev_word || out_valid !== 1'b1) stab_viol++;
            end
            if (out_valid && out_ready) rx_q.push_back({out_last, out_cnt, out_data});
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_cnt, out_data};
        end
    end

    int total = 0;
    int bad   = 0;
    int base  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
        logic acc;
        acc      = 1'b0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_keep  = 8'h00;
        in_last  = 1'b0;
        check({tag, "_accepted"}, 64'(acc), 64'd1);
    endtask

    task automatic expect_word(input string tag, input int k, input logic [31:0] d,
                               input logic [1:0] c, input logic l);
        logic [34:0] w;
        if (base + k < rx_q.size()) w = rx_q[base + k];
        else                        w = 'x;
        check($sformatf("%s_w%0d_data", tag, k), 64'(w[31:0]),  64'(d));
        check($sformatf("%s_w%0d_cnt",  tag, k), 64'(w[33:32]), 64'(c));
        check($sformatf("%s_w%0d_last", tag, k), 64'(w[34]),    64'(l));
    endtask

    task automatic expect_count(input string tag, input int n);
        check({tag, "_nwords"}, 64'(rx_q.size() - base), 64'(n));
    endtask

    logic [7:0] t4_keep [8] = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h01, 8'hF0, 8'h55};

    initial begin
        logic [7:0]  exp_b[$];
        logic [63:0] d;
        logic [31:0] ed;
        logic [1:0]  ec;
        int          nb;
        int          nw;
        int          rem;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_keep  = '0;
        in_last  = 1'b0;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_cnt",   64'(out_cnt),   64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Three full 8-byte beats -> six words, last one full
        base = rx_q.size();
        send("t1_b0", 64'h17161514_13121110, 8'hFF, 1'b0);
        send("t1_b1", 64'h27262524_23222120, 8'hFF, 1'b0);
        send("t1_b2", 64'h37363534_33323130, 8'hFF, 1'b1);
        idle(10);
        expect_count("t1", 6);
        expect_word("t1", 0, 32'h13121110, 2'd0, 1'b0);
        expect_word("t1", 1, 32'h17161514, 2'd0, 1'b0);
        expect_word("t1", 2, 32'h23222120, 2'd0, 1'b0);
        expect_word("t1", 3, 32'h27262524, 2'd0, 1'b0);
        expect_word("t1", 4, 32'h33323130, 2'd0, 1'b0);
        expect_word("t1", 5, 32'h37363534, 2'd0, 1'b1);

        // Sparse keep 0xA5 then 0x01 last -> {D0,D2,D5,D7} then {E0}
        base = rx_q.size();
        send("t2_b0", 64'hD7D6D5D4_D3D2D1D0, 8'hA5, 1'b0);
        send("t2_b1", 64'hE7E6E5E4_E3E2E1E0, 8'h01, 1'b1);
        idle(10);
        expect_count("t2", 2);
        expect_word("t2", 0, 32'hD7D5D2D0, 2'd0, 1'b0);
        expect_word("t2", 1, 32'h000000E0, 2'd1, 1'b1);

        // Empty packet emits nothing; the next packet emits one full last word
        base = rx_q.size();
        send("t3_b0", 64'h99999999_99999999, 8'h00, 1'b0);
        send("t3_b1", 64'h88888888_88888888, 8'h00, 1'b1);
        idle(5);
        expect_count("t3_empty", 0);
        send("t3_b2", 64'h47464544_43424140, 8'h0F, 1'b1);
        idle(10);
        expect_count("t3", 1);
        expect_word("t3", 0, 32'h43424140, 2'd0, 1'b1);

        // Toggling out_ready with mixed keeps; expected stream built from the keep table
        base = rx_q.size();
        rdy_mode = 2;
        exp_b.delete();
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                d[i*8 +: 8] = 8'(128 + 8 * b + i);
                if (t4_keep[b][i]) exp_b.push_back(8'(128 + 8 * b + i));
            end
            send($sformatf("t4_b%0d", b), d, t4_keep[b], (b == 7) ? 1'b1 : 1'b0);
        end
        idle(40);
        rdy_mode = 1;
        idle(2);
        nb = exp_b.size();
        nw = (nb + 3) / 4;
        expect_count("t4", nw);
        for (int w = 0; w < nw; w++) begin
            ed = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < nb) ed[j*8 +: 8] = exp_b[4 * w + j];
            end
            rem = nb - 4 * w;
            ec  = ((w == nw - 1) && (rem < 4)) ? 2'(rem) : 2'd0;
            expect_word("t4", w, ed, ec, (w == nw - 1) ? 1'b1 : 1'b0);
        end
        check("t4_stalls_seen", 64'(stab_chk > 0), 64'd1);
        check("t4_stall_stable", 64'(stab_viol), 64'd0);

        // Last beat accepted while the slot is stalled; next packet must wait
        base = rx_q.size();
        rdy_mode = 0;
        idle(2);
        send("t5_a", 64'hA7A6A5A4_A3A2A1A0, 8'hFF, 1'b1);
        in_data  = 64'hB7B6B5B4_B3B2B1B0;
        in_keep  = 8'h0F;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("t5_blocked%0d", n), 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        send("t5_b", 64'hB7B6B5B4_B3B2B1B0, 8'h0F, 1'b1);
        idle(10);
        expect_count("t5", 3);
        expect_word("t5", 0, 32'hA3A2A1A0, 2'd0, 1'b0);
        expect_word("t5", 1, 32'hA7A6A5A4, 2'd0, 1'b1);
        expect_word("t5", 2, 32'hB3B2B1B0, 2'd0, 1'b1);
        check("t5_stall_stable", 64'(stab_viol), 64'd0);

        // Reset mid-packet with lvl=3 and a held word in the slot
        rdy_mode = 0;
        idle(2);
        send("t6_a", 64'hC7C6C5C4_C3C2C1C0, 8'h7F, 1'b0);
        idle(3);
        @(negedge clk);
        check("t6_pre_lvl",   64'(dut.r_lvl), 64'd3);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 64'(out_valid),  64'd0);
        check("t6_rst_lvl",   64'(dut.r_lvl),  64'd0);
        check("t6_rst_data",  64'(out_data),   64'd0);
        check("t6_rst_ready", 64'(in_ready),   64'd1);
        @(posedge clk);
        #1;
        base = rx_q.size();
        rdy_mode = 1;
        send("t6_b", 64'hF7F6F5F4_F3F2F1F0, 8'hFF, 1'b1);
        idle(10);
        expect_count("t6", 2);
        expect_word("t6", 0, 32'hF3F2F1F0, 2'd0, 1'b0);
        expect_word("t6", 1, 32'hF7F6F5F4, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/stream_repacker.md
# stream_repacker

Parametrised successor of the stream normalizer. It accepts a byte stream with a per-byte keep mask, which may be non-contiguous, and an input width `IN_BYTES`. It compacts the kept bytes and repacks them into full `OUT_BYTES` words, so only the final word of a packet is partial. The block sits between width-mismatched or sparse producers and the fixed-width stream consumers, and it drives its output from a register.

## Interface
Parameters:
- `IN_BYTES`, default 8: input bus width in bytes; must be ≥ 1.
- `OUT_BYTES`, default 4: output bus width in bytes; must be ≥ 2 and a power of two.
- `IN_BITS` (localparam): `IN_BYTES*8`.
- `OUT_BITS` (localparam): `OUT_BYTES*8`.
- `CNT_BITS` (localparam): `$clog2(OUT_BYTES)`.
- `BUF_BYTES` (localparam): `IN_BYTES+OUT_BYTES`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `in_data`, in, `IN_BITS`: input bytes; byte i is `in_data[i*8+:8]`.
- `in_keep`, in, `IN_BYTES`: bit i=1 means byte i is valid; any pattern is allowed, including all-zero.
- `in_last`, in, 1: marks the final beat of a packet.
- `in_valid`, in, 1: input handshake valid.
- `in_ready`, out, 1: input handshake ready.
- `out_data`, out, `OUT_BITS`: packed output word; the lowest byte is first.
- `out_cnt`, out, `CNT_BITS`: bytes in the last word; 0 means `OUT_BYTES`; always 0 when `out_last=0`.
- `out_last`, out, 1: marks the final word of a packet.
- `out_valid`, out, 1: output handshake valid.
- `out_ready`, in, 1: output handshake ready.

## Operation
- Internal state:
  - byte buffer `buf[BUF_BYTES]`;
  - fill level `lvl`, range 0..`BUF_BYTES`;
  - `flush` flag;
  - output slot (`out_data`, `out_cnt`, `out_last`, `out_valid` registers).
- Compaction: the kept bytes of an accepted beat are packed, in ascending index order, to positions `lvl..lvl+k-1`, where `k=popcount(in_keep)`. Order of dropped-byte gaps is irrelevant.
- Slot load ("pop"): occurs when the slot is free (`!out_valid || out_ready`) and either condition holds:
  - `lvl ≥ OUT_BYTES`: load bytes 0..`OUT_BYTES-1` and shift the buffer down by `OUT_BYTES`.
    - `out_last` = `flush && lvl == OUT_BYTES`.
    - `out_cnt` = 0.
  - `flush && 0 < lvl < OUT_BYTES`: load the remaining bytes; zero the upper bytes.
    - `out_last` = 1.
    - `out_cnt` = `lvl`.
- The effective level for the input decision is `lvl_eff = lvl - (pop ? min(lvl,OUT_BYTES) : 0)`.
- `in_ready = !flush && lvl_eff < OUT_BYTES`.
  - `in_ready` never depends on `in_valid`.
  - A combinational path from `out_ready` to `in_ready` is permitted.
- Same-cycle accept and pop: the shift is applied first, then the new bytes are appended at `lvl_eff`.
- Accepting a beat with `in_last=1` sets `flush`. `flush` clears in the cycle the slot is loaded with an `out_last=1` word.
- Zero-byte packet (`flush` with `lvl==0`, i.e. every keep mask in the packet was zero): `flush` clears on the next cycle and nothing is emitted.
- Non-last beats with `in_keep==0` are accepted and have no effect.
- While `out_valid && !out_ready`, the slot and all its outputs hold stable.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `out_cnt`=0, `out_data`=0;
  - `lvl`=0, `flush`=0;
  - therefore `in_ready`=1 the cycle after reset deasserts.
- Reset mid-packet discards all buffered bytes and the slot contents. No partial word is emitted.
- Latency: a beat accepted at edge N that makes `lvl ≥ OUT_BYTES` (or that is last) gives `out_valid`=1 after edge N+1, provided the slot is free.
- Throughput: one input beat per cycle is sustained while `popcount(in_keep) ≤ OUT_BYTES` on average and `out_ready`=1.
- After a last word is loaded, `in_ready` may rise in the same cycle, because `flush` clears at that edge. The new packet's bytes never merge into the old packet's last word.
- Level arithmetic uses `$clog2(BUF_BYTES+1)` bits. `lvl` never exceeds `OUT_BYTES-1+IN_BYTES`; exceeding it is an assertion failure.

## Structure
- Package `stream_pkg` holds:
  - `function popcount`;
  - the cnt encode/decode helpers (0 ↔ `OUT_BYTES`), shared with `stream_normalizer`.
- Sub-module `stream_keep_compactor #(IN_BYTES)` is combinational: inputs `in_data`, `in_keep`; outputs `comp_data` (packed bytes, low first) and `comp_cnt`. It uses prefix-popcount byte selection and must be Yosys-compatible, with no variable part-select writes.
- The top level contains the buffer, level counter, flush logic and output slot.

## Test plan
- `IN=8`, `OUT=4`: full keeps `0xFF` ×3, last on beat 3, `out_ready`=1 → 6 words; 6th word has `out_last`=1, `out_cnt`=0; no input bubbles except the required backpressure.
- Keep `0xA5` then `0x01` with last → 5 bytes `{d0,d2,d5,d7,e0}`, output as a full word then a last word with `out_cnt`=1.
- Packet of keeps `0x00`, `0x00`(last), followed by a packet with keep `0x0F`(last) → only one word emitted, `out_last`=1, `out_cnt`=0.
- `out_ready` toggled 1010… with random keeps → output byte sequence equals the compacted input sequence; `out_data` stable while stalled.
- Last beat accepted while the slot is stalled, followed by the next packet → the first word of the new packet contains no old bytes; `in_ready`=0 until the old last word is loaded.
- Assert `rst_n`=0 with `lvl`=3 and `out_valid`=1 → next cycle `out_valid`=0 and `lvl`=0; the following packet is output intact.
